key_4x4_scan: RTL

- Column-scanning controller for the 4x4 matrix keypad.
- Drives Key_Col into the keypad and reads Key_Row back from it.
- Debounces press and release, locates the pressed key, and emits a 4-bit key code with a one-cycle flag to downstream logic (display/decoder).
- Sits directly between the keypad pins (or the keypad bench model) and the application logic.

---
 rtl/key_4x4_scan_if.sv | 30 +++
 rtl/key_4x4_scan.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/key_4x4_scan_if.sv
// Keypad pin and key-event bundle for key_4x4_scan.
// Optional Key_Rel_Flag exists only when KEY_REL_FLAG_EN is defined.
interface key_4x4_scan_if;
    logic [3:0] Key_Row;
    logic [3:0] Key_Col;
    logic       Key_Flag;
    logic [3:0] Key_Value;
    logic       Key_State;
`ifdef KEY_REL_FLAG_EN
    logic       Key_Rel_Flag;

    modport master (
        input  Key_Row,
        output Key_Col, Key_Flag, Key_Value, Key_State, Key_Rel_Flag
    );
    modport slave (
        output Key_Row,
        input  Key_Col, Key_Flag, Key_Value, Key_State, Key_Rel_Flag
    );
`else
    modport master (
        input  Key_Row,
        output Key_Col, Key_Flag, Key_Value, Key_State
    );
    modport slave (
        output Key_Row,
        input  Key_Col, Key_Flag, Key_Value, Key_State
    );
`endif
endinterface

// File: rtl/key_4x4_scan.sv
// 4x4 keypad column scanner with press/release debounce and one-cycle key flag.
// Define KEY_REL_FLAG_EN to add the one-cycle Key_Rel_Flag release pulse.
module key_4x4_scan #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int SETTLE_CYC   = 8
) (
    input  logic           Clk,
    input  logic           Rst_n,
    key_4x4_scan_if.master kp
);
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, P_FILT, SCAN, HIT, WAIT_REL, R_FILT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       row_meta_q, row_meta_d;
    logic [3:0]       row_s_q, row_s_d;
    logic [3:0]       key_col_q, key_col_d;
    logic             key_flag_q, key_flag_d;
    logic [3:0]       key_value_q, key_value_d;
    logic             key_state_q, key_state_d;
    logic             rel_done;
    logic             row_idle;
    logic [1:0]       row_idx;

    always_comb begin
        row_meta_d = kp.Key_Row;
        row_s_d    = row_meta_q;
    end

    assign row_idle = (row_s_q == 4'b1111);

    // Lowest-index low row wins when several rows answer the same column.
    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s_q[i]) row_idx = 2'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        col_d       = col_q;
        key_value_d = key_value_q;
        key_state_d = key_state_q;
        rel_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!row_idle) begin
                    state_d = P_FILT;
                    cnt_d   = '0;
                end
            end
            P_FILT: begin
                if (row_idle) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = SCAN;
                    col_d    = 2'd0;
                    settle_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SCAN: begin
                if (settle_q != SET_LAST) begin
                    settle_d = settle_q + 1'b1;
                end else if (!row_idle) begin
                    // Value and state change together with the flag.
                    key_value_d = {row_idx, col_q};
                    key_state_d = 1'b1;
                    state_d     = HIT;
                end else if (col_q != 2'd3) begin
                    col_d    = col_q + 2'd1;
                    settle_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            HIT: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (row_idle) begin
                    state_d = R_FILT;
                    cnt_d   = '0;
                end
            end
            R_FILT: begin
                if (!row_idle) begin
                    state_d = WAIT_REL;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    key_state_d = 1'b0;
                    rel_done    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        key_flag_d = (state_d == HIT);
        key_col_d  = (state_d == SCAN) ? ~(4'b0001 << col_d) : 4'b0000;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            settle_q    <= '0;
            col_q       <= 2'd0;
            row_meta_q  <= 4'b1111;
            row_s_q     <= 4'b1111;
            key_col_q   <= 4'b0000;
            key_flag_q  <= 1'b0;
            key_value_q <= 4'd0;
            key_state_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            col_q       <= col_d;
            row_meta_q  <= row_meta_d;
            row_s_q     <= row_s_d;
            key_col_q   <= key_col_d;
            key_flag_q  <= key_flag_d;
            key_value_q <= key_value_d;
            key_state_q <= key_state_d;
        end
    end

    assign kp.Key_Col   = key_col_q;
    assign kp.Key_Flag  = key_flag_q;
    assign kp.Key_Value = key_value_q;
    assign kp.Key_State = key_state_q;

`ifdef KEY_REL_FLAG_EN
    logic rel_flag_q, rel_flag_d;

    always_comb begin
        rel_flag_d = rel_done;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rel_flag_q <= 1'b0;
        end else begin
            rel_flag_q <= rel_flag_d;
        end
    end

    assign kp.Key_Rel_Flag = rel_flag_q;
`else
    logic unused_rel;
    assign unused_rel = rel_done;
`endif

endmodule
